// File: rtl/shot_responder.sv
// Defender-side shot responder: holds the fleet map, answers incoming shots with a verdict over valid/ack.
// Shot accept to resp_valid is 3 clk; the verdict is held until resp_ack, and no new shot is taken meanwhile.
module shot_responder #(
  parameter int GRID_ROWS = 10,
  parameter int GRID_COLS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       board_clear,
  input  logic       place_en,
  input  logic [7:0] place_addr,
  input  logic       shot_valid,
  input  logic [7:0] shot_addr,
  output logic       shot_ready,
  output logic       resp_valid,
  output logic [1:0] resp_msg,
  input  logic       resp_ack,
  output logic [7:0] ship_cells,
  output logic [7:0] hits_taken,
  output logic       fleet_sunk,
  input  logic [7:0] disp_addr,
  output logic [1:0] disp_cell
);

  localparam int NCELL = GRID_ROWS * GRID_COLS;
  localparam int IW    = $clog2(NCELL);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] REPLY  = 2'd3;

  function automatic logic in_range(input logic [7:0] a);
    return (32'(a[7:4]) < GRID_ROWS) && (32'(a[3:0]) < GRID_COLS);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [7:0] a);
    return IW'(32'(a[7:4]) * GRID_COLS + 32'(a[3:0]));
  endfunction

  logic [1:0]       state_q, state_d;
  logic [NCELL-1:0] ship_q, ship_d;
  logic [NCELL-1:0] hit_q, hit_d;
  logic [7:0]       shot_addr_q, shot_addr_d;
  logic [1:0]       cell_q, cell_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_msg_q, resp_msg_d;
  logic [7:0]       ship_cells_q, ship_cells_d;
  logic [7:0]       hits_taken_q, hits_taken_d;
  logic             fleet_sunk_q, fleet_sunk_d;
  logic [1:0]       disp_cell_q, disp_cell_d;

  logic [IW-1:0] place_idx, shot_idx, disp_idx;

  assign place_idx = cell_idx(place_addr);
  assign shot_idx  = cell_idx(shot_addr_q);
  assign disp_idx  = cell_idx(disp_addr);

  always_comb begin
    state_d      = state_q;
    ship_d       = ship_q;
    hit_d        = hit_q;
    shot_addr_d  = shot_addr_q;
    cell_d       = cell_q;
    resp_valid_d = resp_valid_q;
    resp_msg_d   = resp_msg_q;
    ship_cells_d = ship_cells_q;
    hits_taken_d = hits_taken_q;
    fleet_sunk_d = fleet_sunk_q;
    disp_cell_d  = in_range(disp_addr) ? {hit_q[disp_idx], ship_q[disp_idx]} : 2'b00;

    case (state_q)
      IDLE: begin
        if (game_active) begin
          if (shot_valid) begin
            shot_addr_d = shot_addr;
            state_d     = LOOKUP;
          end
        end else if (board_clear) begin
          ship_d       = '0;
          hit_d        = '0;
          ship_cells_d = 8'd0;
          hits_taken_d = 8'd0;
          fleet_sunk_d = 1'b0;
        end else if (place_en && in_range(place_addr) && !ship_q[place_idx]) begin
          ship_d[place_idx] = 1'b1;
          ship_cells_d      = ship_cells_q + 8'd1;
        end
      end
      LOOKUP: begin
        cell_d  = in_range(shot_addr_q) ? {hit_q[shot_idx], ship_q[shot_idx]} : 2'b00;
        state_d = UPDATE;
      end
      UPDATE: begin
        // Only an unhit ship cell scores; a repeat on a hit cell counts as a miss.
        if (cell_q == 2'b01) begin
          hit_d[shot_idx] = 1'b1;
          hits_taken_d    = hits_taken_q + 8'd1;
          if (hits_taken_q + 8'd1 == ship_cells_q) begin
            resp_msg_d   = 2'b11;
            fleet_sunk_d = 1'b1;
          end else begin
            resp_msg_d = 2'b10;
          end
        end else begin
          resp_msg_d = 2'b01;
        end
        resp_valid_d = 1'b1;
        state_d      = REPLY;
      end
      default: begin
        if (resp_ack) begin
          resp_valid_d = 1'b0;
          resp_msg_d   = 2'b00;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ship_q       <= '0;
      hit_q        <= '0;
      shot_addr_q  <= 8'd0;
      cell_q       <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_msg_q   <= 2'b00;
      ship_cells_q <= 8'd0;
      hits_taken_q <= 8'd0;
      fleet_sunk_q <= 1'b0;
      disp_cell_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      ship_q       <= ship_d;
      hit_q        <= hit_d;
      shot_addr_q  <= shot_addr_d;
      cell_q       <= cell_d;
      resp_valid_q <= resp_valid_d;
      resp_msg_q   <= resp_msg_d;
      ship_cells_q <= ship_cells_d;
      hits_taken_q <= hits_taken_d;
      fleet_sunk_q <= fleet_sunk_d;
      disp_cell_q  <= disp_cell_d;
    end
  end

  // Gated by rst so the handshake drops as soon as reset asserts.
  assign shot_ready = rst && game_active && (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_msg   = resp_msg_q;
  assign ship_cells = ship_cells_q;
  assign hits_taken = hits_taken_q;
  assign fleet_sunk = fleet_sunk_q;
  assign disp_cell  = disp_cell_q;

endmodule

// File: tb/tb_shot_responder.sv
// Directed bench for shot_responder: placement and shot vector tables plus hand-written corner sequences.
module tb_shot_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_active, board_clear, place_en, shot_valid, resp_ack;
  logic [7:0] place_addr, shot_addr, disp_addr;
  logic       shot_ready, resp_valid, fleet_sunk;
  logic [1:0] resp_msg, disp_cell;
  logic [7:0] ship_cells, hits_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shot_responder #(.GRID_ROWS(10), .GRID_COLS(10)) dut (
    .clk(clk), .rst(rst), .game_active(game_active), .board_clear(board_clear),
    .place_en(place_en), .place_addr(place_addr), .shot_valid(shot_valid),
    .shot_addr(shot_addr), .shot_ready(shot_ready), .resp_valid(resp_valid),
    .resp_msg(resp_msg), .resp_ack(resp_ack), .ship_cells(ship_cells),
    .hits_taken(hits_taken), .fleet_sunk(fleet_sunk), .disp_addr(disp_addr),
    .disp_cell(disp_cell)
  );

  typedef struct {
    logic       clr;
    logic       en;
    logic [7:0] addr;
    logic [7:0] exp_cells;
  } place_vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [1:0] exp_msg;
    logic [7:0] exp_hits;
    logic       exp_sunk;
  } shot_vec_t;

  place_vec_t pv[10];
  shot_vec_t  sv[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic place(input logic clr, input logic en, input logic [7:0] a, input logic [7:0] exp);
    board_clear = clr;
    place_en    = en;
    place_addr  = a;
    @(negedge clk);
    board_clear = 1'b0;
    place_en    = 1'b0;
    check("ship_cells", 32'(ship_cells), 32'(exp));
  endtask

  task automatic do_shot(input logic [7:0] a, input logic [1:0] m, input logic [7:0] h, input logic s);
    check("ready_idle", 32'(shot_ready), 32'd1);
    shot_valid = 1'b1;
    shot_addr  = a;
    @(negedge clk);
    shot_valid = 1'b0;
    check("ready_busy", 32'(shot_ready), 32'd0);
    check("valid_early1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("valid_early2", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_msg", 32'(resp_msg), 32'(m));
    check("hits_taken", 32'(hits_taken), 32'(h));
    check("fleet_sunk", 32'(fleet_sunk), 32'(s));
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    check("valid_after_ack", 32'(resp_valid), 32'd0);
    check("msg_after_ack", 32'(resp_msg), 32'd0);
  endtask

  task automatic disp(input logic [7:0] a, input logic [1:0] exp);
    disp_addr = a;
    @(negedge clk);
    check("disp_cell", 32'(disp_cell), 32'(exp));
  endtask

  initial begin
    // {clear, place_en, addr, expected ship_cells}
    pv[0] = '{1'b0, 1'b1, 8'h12, 8'd1};
    pv[1] = '{1'b0, 1'b1, 8'h12, 8'd1};
    pv[2] = '{1'b0, 1'b1, 8'hAA, 8'd1};
    pv[3] = '{1'b0, 1'b1, 8'h09, 8'd2};
    pv[4] = '{1'b0, 1'b1, 8'h0A, 8'd2};
    pv[5] = '{1'b1, 1'b1, 8'h33, 8'd0};
    pv[6] = '{1'b0, 1'b1, 8'h00, 8'd1};
    pv[7] = '{1'b0, 1'b1, 8'h01, 8'd2};
    pv[8] = '{1'b0, 1'b1, 8'h12, 8'd3};
    pv[9] = '{1'b0, 1'b1, 8'hA0, 8'd3};
    // {shot addr, expected msg, hits_taken, fleet_sunk}
    sv[0] = '{8'h01, 2'b10, 8'd1, 1'b0};
    sv[1] = '{8'h55, 2'b01, 8'd1, 1'b0};
    sv[2] = '{8'h01, 2'b01, 8'd1, 1'b0};
    sv[3] = '{8'h00, 2'b10, 8'd2, 1'b0};
    sv[4] = '{8'h12, 2'b11, 8'd3, 1'b1};
    sv[5] = '{8'h33, 2'b01, 8'd3, 1'b1};
    sv[6] = '{8'h12, 2'b01, 8'd3, 1'b1};
    sv[7] = '{8'hFF, 2'b01, 8'd3, 1'b1};

    rst = 1'b0; game_active = 1'b0; board_clear = 1'b0; place_en = 1'b0;
    shot_valid = 1'b0; resp_ack = 1'b0; place_addr = 8'h00; shot_addr = 8'h00;
    disp_addr = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(shot_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_msg", 32'(resp_msg), 32'd0);
    check("rst_cells", 32'(ship_cells), 32'd0);
    check("rst_hits", 32'(hits_taken), 32'd0);
    check("rst_sunk", 32'(fleet_sunk), 32'd0);
    check("rst_disp", 32'(disp_cell), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) place(pv[i].clr, pv[i].en, pv[i].addr, pv[i].exp_cells);
    disp(8'h01, 2'b01);
    disp(8'h02, 2'b00);
    disp(8'h09, 2'b00);

    // Shots during placement are ignored.
    shot_valid = 1'b1; shot_addr = 8'h00;
    repeat (4) @(negedge clk);
    shot_valid = 1'b0;
    check("place_ready", 32'(shot_ready), 32'd0);
    check("place_no_resp", 32'(resp_valid), 32'd0);

    game_active = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) do_shot(sv[i].addr, sv[i].exp_msg, sv[i].exp_hits, sv[i].exp_sunk);
    disp(8'h01, 2'b11);
    disp(8'h55, 2'b00);

    // Verdict held while ack stays low; a pending shot must not be taken.
    shot_valid = 1'b1; shot_addr = 8'h44;
    @(negedge clk);
    shot_addr = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_msg", 32'(resp_msg), 32'd1);
      check("hold_ready", 32'(shot_ready), 32'd0);
      @(negedge clk);
    end
    shot_valid = 1'b0;
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_no_extra", 32'(resp_valid), 32'd0);
    check("hold_hits", 32'(hits_taken), 32'd3);

    // game_active falls mid-shot: shot completes and placement stays blocked.
    shot_valid = 1'b1; shot_addr = 8'h33;
    @(negedge clk);
    shot_valid = 1'b0; game_active = 1'b0; place_en = 1'b1; place_addr = 8'h44;
    @(negedge clk);
    @(negedge clk);
    place_en = 1'b0;
    check("drop_valid", 32'(resp_valid), 32'd1);
    check("drop_msg", 32'(resp_msg), 32'd1);
    resp_ack = 1'b1;
    @(negedge clk);
    resp_ack = 1'b0;
    check("drop_cells", 32'(ship_cells), 32'd3);

    // Clear board, then shooting an empty fleet never sinks it.
    place(1'b1, 1'b0, 8'h00, 8'd0);
    check("clr_hits", 32'(hits_taken), 32'd0);
    check("clr_sunk", 32'(fleet_sunk), 32'd0);
    game_active = 1'b1;
    @(negedge clk);
    do_shot(8'h00, 2'b01, 8'd0, 1'b0);

    // Reset asserted while in UPDATE.
    game_active = 1'b0;
    place(1'b0, 1'b1, 8'h00, 8'd1);
    game_active = 1'b1;
    @(negedge clk);
    shot_valid = 1'b1; shot_addr = 8'h00;
    @(negedge clk);
    shot_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(shot_ready), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_msg", 32'(resp_msg), 32'd0);
    check("mid_rst_cells", 32'(ship_cells), 32'd0);
    check("mid_rst_hits", 32'(hits_taken), 32'd0);
    check("mid_rst_sunk", 32'(fleet_sunk), 32'd0);
    @(negedge clk);
    game_active = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    disp(8'h00, 2'b00);
    check("post_rst_valid", 32'(resp_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
